updown_mod_counter: RTL and testbench

UPDOWN_MOD_COUNTER -- requirements
Module: updown_mod_counter

---
 rtl/updown_mod_counter.sv | 108 ++++++++++
 tb/tb_updown_mod_counter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/updown_mod_counter.sv
// Up/down modulo counter with a runtime terminal value, an enable-gated
// prescaler, a synchronous load and a one-cycle wrap pulse.
// Optional feature: define UPDOWN_MOD_COUNTER_WRAPCNT_EN to add a
// saturating wrap-event counter output (wrap_cnt).
module updown_mod_counter #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned PRESCALE = 1,
    parameter int unsigned WRAP_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              up,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    input  logic [WIDTH-1:0]  max_val,
    output logic [WIDTH-1:0]  count,
`ifdef UPDOWN_MOD_COUNTER_WRAPCNT_EN
    output logic [WRAP_W-1:0] wrap_cnt,
`endif
    output logic              tc
);

    localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

    logic [WIDTH-1:0] r_count;
    logic [PRE_W-1:0] r_pre;
    logic             r_tc;

    logic             w_step;
    logic [WIDTH-1:0] w_next_count;
    logic             w_wrap;
    logic [WIDTH-1:0] w_load_count;

    // Step fires on the last enabled clock of each prescale period
    assign w_step = en && (r_pre == PRE_LAST);

    // Load value clamped to the current terminal value
    assign w_load_count = (load_val > max_val) ? max_val : load_val;

    // Next count and wrap flag for a step in the current direction
    always_comb begin
        w_next_count = r_count;
        w_wrap       = 1'b0;
        if (up) begin
            if (r_count >= max_val) begin
                w_next_count = '0;
                w_wrap       = 1'b1;
            end else begin
                w_next_count = r_count + WIDTH'(1);
            end
        end else begin
            if (r_count > max_val) begin
                // Out-of-range value is pulled back to the top without a wrap
                w_next_count = max_val;
            end else if (r_count == '0) begin
                w_next_count = max_val;
                w_wrap       = 1'b1;
            end else begin
                w_next_count = r_count - WIDTH'(1);
            end
        end
    end

    // Counter, prescaler and wrap pulse registers; rst > load > step > hold
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_pre   <= '0;
            r_tc    <= 1'b0;
        end else if (load) begin
            r_count <= w_load_count;
            r_pre   <= '0;
            r_tc    <= 1'b0;
        end else if (en) begin
            if (w_step) begin
                r_pre   <= '0;
                r_count <= w_next_count;
                r_tc    <= w_wrap;
            end else begin
                r_pre   <= r_pre + PRE_W'(1);
                r_tc    <= 1'b0;
            end
        end else begin
            r_tc <= 1'b0;
        end
    end

    assign count = r_count;
    assign tc    = r_tc;

`ifdef UPDOWN_MOD_COUNTER_WRAPCNT_EN
    logic [WRAP_W-1:0] r_wrap_cnt;

    // Saturating count of wraps since the last reset or load
    always_ff @(posedge clk) begin
        if (rst || load) begin
            r_wrap_cnt <= '0;
        end else if (w_step && w_wrap && (r_wrap_cnt != '1)) begin
            r_wrap_cnt <= r_wrap_cnt + WRAP_W'(1);
        end
    end

    assign wrap_cnt = r_wrap_cnt;
`endif

endmodule

// File: tb/tb_updown_mod_counter.sv
// Bench for updown_mod_counter: two instances (PRESCALE=1 and PRESCALE=3)
// share one stimulus stream; expected values are queued per edge and
// compared one time unit after the edge.
module tb_updown_mod_counter;

    localparam int unsigned W  = 4;
    localparam int unsigned WW = 2;

    logic         clk;
    logic         rst;
    logic         en;
    logic         up;
    logic         load;
    logic [W-1:0] load_val;
    logic [W-1:0] max_val;

    logic [W-1:0]  a_count;
    logic          a_tc;
    logic [W-1:0]  b_count;
    logic          b_tc;
`ifdef UPDOWN_MOD_COUNTER_WRAPCNT_EN
    logic [WW-1:0] a_wc;
    logic [WW-1:0] b_wc;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [W-1:0]  cnt;
        logic          tc;
        logic [WW-1:0] wc;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    // Reference state per instance: index 0 = PRESCALE 1, index 1 = PRESCALE 3
    int unsigned m_cnt [2];
    int unsigned m_pre [2];
    int unsigned m_tc  [2];
    int unsigned m_wc  [2];
    int unsigned m_psc [2];

    updown_mod_counter #(.WIDTH(W), .PRESCALE(1), .WRAP_W(WW)) dut_a (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
        .load_val(load_val), .max_val(max_val), .count(a_count),
`ifdef UPDOWN_MOD_COUNTER_WRAPCNT_EN
        .wrap_cnt(a_wc),
`endif
        .tc(a_tc)
    );

    updown_mod_counter #(.WIDTH(W), .PRESCALE(3), .WRAP_W(WW)) dut_b (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
        .load_val(load_val), .max_val(max_val), .count(b_count),
`ifdef UPDOWN_MOD_COUNTER_WRAPCNT_EN
        .wrap_cnt(b_wc),
`endif
        .tc(b_tc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance the reference model of instance k by one rising edge
    task automatic model_edge(input int k);
        int unsigned c, mv, lv;
        c  = m_cnt[k];
        mv = int'(max_val);
        lv = int'(load_val);
        if (rst) begin
            m_cnt[k] = 0; m_pre[k] = 0; m_tc[k] = 0; m_wc[k] = 0;
        end else if (load) begin
            m_cnt[k] = (lv < mv) ? lv : mv;
            m_pre[k] = 0; m_tc[k] = 0; m_wc[k] = 0;
        end else if (en) begin
            if (m_pre[k] == m_psc[k] - 1) begin
                m_pre[k] = 0;
                m_tc[k]  = 0;
                if (up) begin
                    if (c >= mv) begin m_cnt[k] = 0; m_tc[k] = 1; end
                    else m_cnt[k] = c + 1;
                end else begin
                    if (c > mv) m_cnt[k] = mv;
                    else if (c == 0) begin m_cnt[k] = mv; m_tc[k] = 1; end
                    else m_cnt[k] = c - 1;
                end
                if (m_tc[k] == 1 && m_wc[k] < 3) m_wc[k] = m_wc[k] + 1;
            end else begin
                m_pre[k] = m_pre[k] + 1;
                m_tc[k]  = 0;
            end
        end else begin
            m_tc[k] = 0;
        end
    endtask

    function automatic exp_t pack_exp(input int k);
        exp_t e;
        e.cnt = W'(m_cnt[k]);
        e.tc  = m_tc[k][0];
        e.wc  = WW'(m_wc[k]);
        return e;
    endfunction

    // Drive one cycle of stimulus, queue expectations, then compare both instances
    task automatic cyc(input string tag, input logic i_rst, input logic i_en,
                       input logic i_up, input logic i_load,
                       input logic [W-1:0] i_lv, input logic [W-1:0] i_mv);
        exp_t ea, eb;
        rst = i_rst; en = i_en; up = i_up; load = i_load;
        load_val = i_lv; max_val = i_mv;
        model_edge(0);
        model_edge(1);
        q_a.push_back(pack_exp(0));
        q_b.push_back(pack_exp(1));
        @(posedge clk);
        #1;
        ea = q_a.pop_front();
        eb = q_b.pop_front();
        checks++;
        assert ({a_count, a_tc} === {ea.cnt, ea.tc}) else begin
            errors++;
            $error("FAIL %s p1 count/tc got %0d/%0b exp %0d/%0b", tag, a_count, a_tc, ea.cnt, ea.tc);
        end
        checks++;
        assert ({b_count, b_tc} === {eb.cnt, eb.tc}) else begin
            errors++;
            $error("FAIL %s p3 count/tc got %0d/%0b exp %0d/%0b", tag, b_count, b_tc, eb.cnt, eb.tc);
        end
`ifdef UPDOWN_MOD_COUNTER_WRAPCNT_EN
        checks++;
        assert ({a_wc, b_wc} === {ea.wc, eb.wc}) else begin
            errors++;
            $error("FAIL %s wrap_cnt got %0d/%0d exp %0d/%0d", tag, a_wc, b_wc, ea.wc, eb.wc);
        end
`endif
    endtask

    // Fixed-value check on the PRESCALE=1 instance
    task automatic fixed(input string tag, input logic [W-1:0] c, input logic t);
        checks++;
        assert ({a_count, a_tc} === {c, t}) else begin
            errors++;
            $error("FAIL %s fixed got %0d/%0b exp %0d/%0b", tag, a_count, a_tc, c, t);
        end
    endtask

    int tc_seen;

    initial begin
        m_psc[0] = 1; m_psc[1] = 3;
        for (int k = 0; k < 2; k++) begin
            m_cnt[k] = 0; m_pre[k] = 0; m_tc[k] = 0; m_wc[k] = 0;
        end
        rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = '0; max_val = '0;
        #2;

        cyc("reset", 1, 0, 1, 0, 0, 15);
        fixed("reset_zero", 0, 0);

        // Full-range up count: wraps once after 15
        tc_seen = 0;
        for (int i = 0; i < 18; i++) begin
            cyc("up15", 0, 1, 1, 0, 0, 15);
            if (a_tc) tc_seen++;
            if (i == 15) fixed("up15_wrap", 0, 1);
        end
        fixed("up15_end", 2, 0);
        checks++;
        assert (tc_seen == 1) else begin
            errors++;
            $error("FAIL up15_tc_count got %0d exp 1", tc_seen);
        end

        // Down count modulo 10 from 0
        cyc("rst2", 1, 0, 0, 0, 0, 9);
        cyc("dn9_first", 0, 1, 0, 0, 0, 9);
        fixed("dn9_wrap", 9, 1);
        for (int i = 0; i < 10; i++) cyc("dn9", 0, 1, 0, 0, 0, 9);
        fixed("dn9_rewrap", 9, 1);

        // Prescaled count with an enable gap
        cyc("rst3", 1, 0, 1, 0, 0, 2);
        for (int i = 0; i < 9; i++) cyc("psc", 0, 1, 1, 0, 0, 2);
        cyc("psc_hold", 0, 1, 1, 0, 0, 2);
        cyc("psc_gap0", 0, 0, 1, 0, 0, 2);
        cyc("psc_gap1", 0, 0, 1, 0, 0, 2);
        for (int i = 0; i < 4; i++) cyc("psc_resume", 0, 1, 1, 0, 0, 2);

        // Load clamps to max_val; load beats a coincident step
        cyc("load_clamp", 0, 0, 1, 1, 12, 7);
        fixed("load_clamp", 7, 0);
        cyc("load_step", 0, 1, 1, 1, 3, 7);
        fixed("load_step", 3, 0);

        // Terminal value lowered below the current count
        cyc("ld10_up", 0, 0, 1, 1, 10, 15);
        cyc("low_up", 0, 1, 1, 0, 0, 5);
        fixed("low_up", 0, 1);
        cyc("ld10_dn", 0, 0, 1, 1, 10, 15);
        cyc("low_dn", 0, 1, 0, 0, 0, 5);
        fixed("low_dn", 5, 0);

        // max_val = 0: every step wraps; wrap counter saturates
        cyc("rst4", 1, 0, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cyc("mv0", 0, 1, 1, 0, 0, 0);
            fixed("mv0", 0, 1);
        end
`ifdef UPDOWN_MOD_COUNTER_WRAPCNT_EN
        checks++;
        assert (a_wc === 2'd3) else begin
            errors++;
            $error("FAIL wrap_sat got %0d exp 3", a_wc);
        end
`endif

        // Reset mid-prescale with load and enable asserted
        cyc("pre_a", 0, 1, 1, 0, 0, 9);
        cyc("rst_all", 1, 1, 1, 1, 6, 9);
        fixed("rst_all", 0, 0);

        // Random mix
        for (int i = 0; i < 60; i++) begin
            cyc("rand", ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
                1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0),
                W'($urandom_range(0, 15)), W'($urandom_range(0, 15)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
